piso_right_shift_register: RTL and testbench
============================================

PISO_RIGHT_SHIFT_REGISTER -- requirements
Module: piso_right_shift_register

Interface
REQ-001 SHALL have parameter: SIZE, default 8, word width in bits (SIZE >= 2).
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: data_in  input  SIZE  parallel word to serialize.
REQ-005 SHALL have port: load_valid  input  1  request to capture data_in.
REQ-006 SHALL have port: load_ready  output  1  high when a load is accepted this cycle.
REQ-007 SHALL have port: enable  input  1  shift-advance qualifier.
REQ-008 SHALL have port: serial_out  output  1  current serial bit, LSB first.
REQ-009 SHALL have port: shift_strobe  output  1  high in cycles where serial_out is consumed; drives the receiving shift register's enable.
REQ-010 SHALL have port: busy  output  1  high while a word is being shifted out.
REQ-011 SHALL have port: done  output  1  one-cycle pulse after the last bit of a word is shifted.

Function
REQ-012 SHALL implement states IDLE and SHIFT; busy = (state == SHIFT).
REQ-013 SHALL assert load_ready combinationally iff state == IDLE and reset is low.
REQ-014 SHALL, on load_valid & load_ready, capture data_in into a SIZE-bit shift register, clear the bit counter, and enter SHIFT next cycle.
REQ-015 SHALL ignore load_valid while in SHIFT, with no capture and no effect on the word in progress.
REQ-016 SHALL drive serial_out = shift_reg[0] in SHIFT, and 0 in IDLE.
REQ-017 SHALL drive shift_strobe = (state == SHIFT) & enable, combinationally.
REQ-018 SHALL, on each SHIFT cycle with enable=1, shift shift_reg right by one with 0 into the MSB and increment the counter (width $clog2(SIZE)).
REQ-019 SHALL, on each SHIFT cycle with enable=0, hold shift_reg, counter and state, with serial_out stable.
REQ-020 SHALL, on an enabled SHIFT cycle with counter == SIZE-1 (final bit), return to IDLE and assert done for exactly the next cycle.
REQ-021 SHALL present exactly SIZE shift_strobe cycles per accepted word, bit i of the loaded word on the i-th strobe (i = 0..SIZE-1).
REQ-022 SHALL be bit-order compatible with the team's right_shift_register (data into MSB, shifting right): after SIZE strobes, with shift_strobe driving its enable, that register holds the original word.
REQ-023 SHALL accept a new load in the cycle done is high (state is IDLE), giving a minimum of 1 idle cycle between words.
REQ-024 SHALL ignore enable while in IDLE.

Reset
REQ-025 SHALL, when reset=1 at a rising edge, force IDLE, clear shift_reg and counter to 0, and clear done to 0, overriding load_valid and enable.
REQ-026 SHALL hold outputs during reset and on the first cycle after it at: serial_out=0, shift_strobe=0, busy=0, done=0; load_ready=0 while reset is high and 1 after.
REQ-027 SHALL, on reset during SHIFT, abort the word with no done pulse and no further strobes.

Verification
REQ-028 SHALL cover a basic word: SIZE=8, load 8'hA5, enable=1 constantly -> serial_out 1,0,1,0,0,1,0,1 on 8 consecutive strobes, then done one cycle, busy low.
REQ-029 SHALL cover a stalled shift: load 8'h3C, enable toggled 1,0,0,1,... -> serial_out holds during enable=0 cycles, exactly 8 strobes total, done after the 8th.
REQ-030 SHALL cover loopback: serial_out->right_shift_register.data_in, shift_strobe->enable, load 8'hC3 -> receiver out == 8'hC3 on the cycle done is high.
REQ-031 SHALL cover a load while busy: load 8'h01, assert load_valid with data_in 8'hFF at bit 3 -> ignored, bit stream still 8'h01.
REQ-032 SHALL cover a mid-word reset: load 8'hFF, assert reset after 4 strobes -> next cycle busy=0, serial_out=0, no done; new load 8'h81 then serializes correctly.
REQ-033 SHALL cover back-to-back loads: load_valid held high with 8'h12 then 8'h34 -> second word accepted on the done cycle, 16 strobes total, 2 done pulses.

Source files
------------

// File: rtl/piso_right_shift_register.sv
// Parallel-in, serial-out shifter: captures a word on a ready/valid load and
// emits it LSB first, one bit per enabled cycle, with a strobe for the receiver.
module piso_right_shift_register #(
  parameter int unsigned SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [SIZE-1:0] data_in,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic            enable,
  output logic            serial_out,
  output logic            shift_strobe,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [SIZE-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            done_q, done_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      count     <= count_nxt;
      done_q    <= done_nxt;
    end
  end

  // Strobe and serial data are gated by reset so an aborted word emits nothing
  // further even in the cycle reset is first seen.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_reg;
    count_nxt    = count;
    done_nxt     = 1'b0;
    load_ready   = (state == IDLE) && !reset;
    shift_strobe = (state == SHIFT) && enable && !reset;
    serial_out   = (state == SHIFT) && !reset && shift_reg[0];

    case (state)
      IDLE: begin
        if (load_valid && load_ready) begin
          shift_nxt = data_in;
          count_nxt = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (enable) begin
          shift_nxt = {1'b0, shift_reg[SIZE-1:1]};
          if (count == LAST) begin
            count_nxt = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);
  assign done = done_q;

endmodule

// File: tb/tb_piso_right_shift_register.sv
// Self-checking bench for piso_right_shift_register: directed vector table,
// hand-written corner sequences and randomized traffic against a word/index model.
module tb_piso_right_shift_register;

  localparam int unsigned SIZE = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [SIZE-1:0] data_in;
  logic            load_valid;
  logic            load_ready;
  logic            enable;
  logic            serial_out;
  logic            shift_strobe;
  logic            busy;
  logic            done;

  always #5 clk = ~clk;

  piso_right_shift_register #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .reset        (reset),
    .data_in      (data_in),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .enable       (enable),
    .serial_out   (serial_out),
    .shift_strobe (shift_strobe),
    .busy         (busy),
    .done         (done)
  );

  // Receiving right shift register: data into MSB, shifting right on strobe.
  logic [SIZE-1:0] rx = '0;
  always @(posedge clk) if (shift_strobe) rx <= {serial_out, rx[SIZE-1:1]};

  int tests = 0;
  int fails = 0;

  // Reference model: word in flight plus the index of the bit on the wire.
  bit              m_busy = 1'b0;
  bit              m_done = 1'b0;
  logic [SIZE-1:0] m_word = '0;
  logic [SIZE-1:0] m_last = '0;
  int              m_idx  = 0;

  int              s_strobes;
  int              s_dones;
  logic [SIZE-1:0] s_cap;

  typedef struct {
    logic [SIZE-1:0] word;
    logic [7:0]      en_pat;
    int              busy_bit;
    logic [SIZE-1:0] busy_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("load_ready",   32'(load_ready),   32'(!m_busy && !reset));
    chk("busy",         32'(busy),         32'(m_busy));
    chk("shift_strobe", 32'(shift_strobe), 32'(m_busy && enable && !reset));
    chk("serial_out",   32'(serial_out),   32'((m_busy && !reset) ? m_word[m_idx] : 1'b0));
    chk("done",         32'(done),         32'(m_done));
    if (m_done) chk("loopback", 32'(rx), 32'(m_last));
    if (shift_strobe) begin
      s_strobes++;
      s_cap = {serial_out, s_cap[SIZE-1:1]};
    end
    if (done) s_dones++;
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (load_valid) begin
          m_busy = 1'b1;
          m_word = data_in;
          m_idx  = 0;
        end
      end else if (enable) begin
        if (m_idx == SIZE - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_last = m_word;
        end else begin
          m_idx++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    s_strobes = 0;
    s_dones   = 0;
    s_cap     = '0;
  endtask

  task automatic run_vec(input vec_t v);
    clear_counts();
    load_valid = 1'b1;
    data_in    = v.word;
    enable     = 1'b0;
    step();
    load_valid = 1'b0;
    for (int c = 0; c < 100 && s_dones == 0; c++) begin
      enable     = v.en_pat[c % 8];
      load_valid = (v.busy_bit >= 0) && (s_strobes == v.busy_bit);
      data_in    = (v.busy_bit >= 0) ? v.busy_data : v.word;
      step();
    end
    load_valid = 1'b0;
    chk("vec_strobes", 32'(s_strobes), SIZE);
    chk("vec_dones",   32'(s_dones),   32'd1);
    chk("vec_bits",    32'(s_cap),     32'(v.word));
    enable = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{word: 8'hA5, en_pat: 8'hFF, busy_bit: -1, busy_data: 8'h00};
    vecs[1] = '{word: 8'h3C, en_pat: 8'h99, busy_bit: -1, busy_data: 8'h00};
    vecs[2] = '{word: 8'hC3, en_pat: 8'hFF, busy_bit: -1, busy_data: 8'h00};
    vecs[3] = '{word: 8'h01, en_pat: 8'hFF, busy_bit: 3,  busy_data: 8'hFF};
    vecs[4] = '{word: 8'h80, en_pat: 8'h55, busy_bit: -1, busy_data: 8'h00};
    vecs[5] = '{word: 8'h00, en_pat: 8'hB6, busy_bit: 0,  busy_data: 8'hFF};

    reset      = 1'b1;
    load_valid = 1'b1;
    enable     = 1'b1;
    data_in    = 8'hFF;
    clear_counts();
    @(posedge clk);
    #1;
    step();
    step();
    reset      = 1'b0;
    load_valid = 1'b0;
    enable     = 1'b0;
    step();
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Mid-word reset after four strobes, then a fresh word.
    clear_counts();
    load_valid = 1'b1;
    data_in    = 8'hFF;
    step();
    load_valid = 1'b0;
    enable     = 1'b1;
    for (int c = 0; c < 20 && s_strobes < 4; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_busy",   32'(busy),       32'd0);
    chk("abort_serial", 32'(serial_out), 32'd0);
    for (int c = 0; c < 3; c++) step();
    chk("abort_strobes", 32'(s_strobes), 32'd4);
    chk("abort_dones",   32'(s_dones),   32'd0);
    run_vec('{word: 8'h81, en_pat: 8'hFF, busy_bit: -1, busy_data: 8'h00});

    // Back-to-back loads with load_valid held high.
    clear_counts();
    load_valid = 1'b1;
    data_in    = 8'h12;
    enable     = 1'b1;
    step();
    data_in = 8'h34;
    for (int c = 0; c < 60 && s_dones < 2; c++) step();
    load_valid = 1'b0;
    chk("b2b_strobes", 32'(s_strobes), 32'd16);
    chk("b2b_dones",   32'(s_dones),   32'd2);
    chk("b2b_last",    32'(s_cap),     32'h34);
    for (int c = 0; c < 30 && (m_busy || m_done); c++) step();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset      = ($urandom_range(0, 49) == 0);
      load_valid = 1'($urandom_range(0, 1));
      enable     = ($urandom_range(0, 9) < 7);
      data_in    = SIZE'($urandom);
      step();
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    enable     = 1'b1;
    for (int c = 0; c < 30 && (m_busy || m_done); c++) step();
    chk("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
